serial_adder: RTL

Bit-serial, LSB-first adder that drives a single full-adder cell once per clock to add two WIDTH-bit operands plus carry-in. It sits directly upstream of the full-adder cell: it feeds that cell one operand bit pair and the registered carry per cycle, and collects the cell's sum and carry outputs. It trades WIDTH cycles of latency for one adder cell, using a start/busy/done handshake toward the requesting logic.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_fa_cell.sv | 23 ++
 rtl/serial_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

  // Controller states. The encoding is fixed so external checkers can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Default operand width, used for the package-level counter constant.
  localparam int WIDTH_DEFAULT = 8;

  // Bits needed to count operand bit positions 0 .. width-1 (width >= 2).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half adders and an OR.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder on the operand bits, second folds in the carry.
  always_comb begin
    ha0_sum   = a_i ^ b_i;
    ha0_carry = a_i & b_i;
    sum_o     = ha0_sum ^ c_i;
    ha1_carry = ha0_sum & c_i;
    carry_o   = ha0_carry | ha1_carry;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell reused for WIDTH cycles.
//
// Handshake: a request is accepted on any rising edge where start=1 while
// the controller is IDLE or DONE; operands and carry-in are captured on that
// edge only. busy is high for exactly WIDTH cycles (state RUN), then done is
// high for one cycle with sum/cout valid. sum/cout hold until the next result
// completes. start is ignored while busy. rst (synchronous) wins over start.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shift_a_q;
  logic [WIDTH-1:0] shift_b_q;
  // Result bits collected so far; the newest cell sum completes the word.
  logic [WIDTH-2:0] res_sh_q;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;
  logic             busy_q;

  logic             cell_sum;
  logic             cell_carry;
  logic [WIDTH-1:0] res_d;

  fa_cell u_fa_cell (
    .a_i     (shift_a_q[0]),
    .b_i     (shift_b_q[0]),
    .c_i     (carry_q),
    .sum_o   (cell_sum),
    .carry_o (cell_carry)
  );

  // Result word including this cycle's cell output, shifted in at the MSB.
  always_comb begin
    res_d = {cell_sum, res_sh_q};
  end

  // Controller, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_sh_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_a_q <= a;
            shift_b_q <= b;
            carry_q   <= cin;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          shift_a_q <= shift_a_q >> 1;
          shift_b_q <= shift_b_q >> 1;
          res_sh_q  <= res_d[WIDTH-1:1];
          carry_q   <= cell_carry;
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            sum_q   <= res_d;
            cout_q  <= cell_carry;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
